// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target blocks: register map, CTRL/STATUS
// bit positions, receive FSM states and the RX FIFO entry layout.
package spi_pkg;

  // Register offsets (address_in[3:0])
  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  // CTRL bits
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  // STATUS bits
  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_OVERFLOW_BIT  = 2;
  localparam int STAT_FRAME_ERR_BIT = 3;
  localparam int STAT_ACTIVE_BIT    = 4;
  localparam int STAT_COUNT_LSB     = 8;
  localparam int STAT_COUNT_W       = 4;

  // DATA register layout above the byte
  localparam int DATA_DC_BIT    = 8;
  localparam int DATA_VALID_BIT = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive FIFO for the SPI target: power-of-two depth, 9-bit entries
// ({dc, byte}), push/pop/flush. A push while full only lands when a pop
// frees the slot in the same cycle; a pop while empty is ignored.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  rx_entry_t                     wdata_i,
  output rx_entry_t                     rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  rx_entry_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Occupancy follows the accepted push/pop pair
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy state; flush empties the queue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while not counted
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/spi_target_rx.sv
// SPI target receiver with bus-readable RX FIFO. SPI pins are synchronized
// into clk, rising spi_clk edges shift MOSI MSB-first, each completed byte
// is queued with the lcd_dc level seen on its 8th edge.
module spi_target_rx
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  input  logic        lcd_dc,
  output logic        irq_out
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q, dc_sync_q, warm_q;
  logic       sclk_s, mosi_s, csn_s, dc_s, sync_warm;
  logic       sclk_prev_q, sclk_rise;
  logic       armed_q, armed_d;
  spi_state_e state_q, state_d;
  logic       frame_active, shift_en, abort_err;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q;
  logic       push_q;
  rx_entry_t  push_data_q;
  logic       enable_q, ovf_q, ferr_q, irq_q;
  logic       rd_req, wr_req, rd_prev_q, ctrl_wr, clr, flush, pop, ovf_evt;
  logic [3:0] offset;
  rx_entry_t  rd_entry;
  logic       fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic       unused_ok;

  assign unused_ok = ^{address_in[31:4], write_value_in[31:3]};

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign sync_warm = warm_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s && !sclk_prev_q;

  // Pin synchronizers, reset to the idle bus levels; warm_q marks when the
  // chains hold real pin samples rather than reset values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      dc_sync_q   <= '0;
      warm_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], lcd_dc};
      warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
    end
  end

  // A frame may only start after cs_n has really been seen high, so a frame
  // interrupted by reset (or by disabling) is never picked up mid-way
  always_comb begin
    armed_d = armed_q;
    if (csn_s && sync_warm) begin
      armed_d = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      armed_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!csn_s && enable_q && armed_q) state_d = ST_SHIFT;
      ST_SHIFT: if (csn_s || !enable_q)            state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: shift strobe and partial-byte abort detection
  always_comb begin
    frame_active = (state_q == ST_SHIFT);
    shift_en     = frame_active && !csn_s && enable_q && sclk_rise;
    abort_err    = frame_active && csn_s && (bit_cnt_q != 3'd0);
  end

  // Bit counter clears whenever the frame ends; the 3-bit wrap restarts
  // each back-to-back byte
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (state_d != ST_SHIFT || state_q != ST_SHIFT) begin
      bit_cnt_d = 3'd0;
    end else if (shift_en) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Bit counter and one-cycle push strobe for a completed byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= 3'd0;
      push_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      push_q    <= shift_en && (bit_cnt_q == 3'd7);
    end
  end

  // Shift register and the completed entry waiting for its push cycle
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shift_q <= {shift_q[6:0], mosi_s};
      if (bit_cnt_q == 3'd7) begin
        push_data_q <= '{dc: dc_s, data: {shift_q[6:0], mosi_s}};
      end
    end
  end

  // Bus decode; DATA pops only on the first cycle of a read
  assign offset    = address_in[3:0];
  assign ready_out = sel_in;
  assign rd_req    = sel_in && read_in;
  assign wr_req    = sel_in && (|write_mask_in);
  assign ctrl_wr   = wr_req && (offset == OFF_CTRL);
  assign clr       = ctrl_wr && write_value_in[CTRL_CLEAR_BIT];
  assign flush     = ctrl_wr && write_value_in[CTRL_FLUSH_BIT];
  assign pop       = rd_req && !rd_prev_q && (offset == OFF_DATA) && !fifo_empty;
  assign ovf_evt   = push_q && fifo_full && !pop;

  spi_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_q),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_data_q),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Control register, sticky flags (a new event beats a clear) and irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q  <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      if (ctrl_wr) enable_q <= write_value_in[CTRL_ENABLE_BIT];
      ovf_q     <= (ovf_q && !clr) || ovf_evt;
      ferr_q    <= (ferr_q && !clr) || abort_err;
      irq_q     <= enable_q && (!fifo_empty || ovf_q || ferr_q);
      rd_prev_q <= rd_req;
    end
  end

  assign irq_out = irq_q;

  // Combinational read mux, zero unless a read is in progress
  always_comb begin
    read_value_out = '0;
    if (rd_req) begin
      case (offset)
        OFF_DATA: begin
          if (!fifo_empty) begin
            read_value_out[7:0]            = rd_entry.data;
            read_value_out[DATA_DC_BIT]    = rd_entry.dc;
            read_value_out[DATA_VALID_BIT] = 1'b1;
          end
        end
        OFF_CTRL: read_value_out[CTRL_ENABLE_BIT] = enable_q;
        OFF_STATUS: begin
          read_value_out[STAT_NOT_EMPTY_BIT] = !fifo_empty;
          read_value_out[STAT_FULL_BIT]      = fifo_full;
          read_value_out[STAT_OVERFLOW_BIT]  = ovf_q;
          read_value_out[STAT_FRAME_ERR_BIT] = ferr_q;
          read_value_out[STAT_ACTIVE_BIT]    = frame_active;
          read_value_out[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
        end
        default: read_value_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_rx.sv
// Bench for spi_target_rx: register table, directed multi-cycle corner
// cases and randomized frames against a queue-based reference model.
module tb_spi_target_rx;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        lcd_dc = 1'b0;
  logic        irq_out;

  int errors = 0;
  int checks = 0;

  logic [8:0] mq[$];
  bit         m_ovf;
  bit         m_ferr;

  typedef struct {
    bit          wr;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[16];

  spi_target_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .address_in(address_in), .sel_in(sel_in),
    .read_in(read_in), .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .read_value_out(read_value_out), .ready_out(ready_out), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    sel_in = 1'b0; read_in = 1'b0; write_mask_in = '0;
    address_in = '0; write_value_in = '0;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] v);
    @(negedge clk);
    address_in = {28'b0, off}; sel_in = 1'b1; read_in = 1'b0;
    write_mask_in = 4'hF; write_value_in = v;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] v);
    @(negedge clk);
    address_in = {28'b0, off}; sel_in = 1'b1; read_in = 1'b1;
    #1 v = read_value_out;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input logic dc);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      lcd_dc   = dc;
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Reference model: queue of {dc, byte} plus sticky flags
  task automatic model_push(input logic dc, input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back({dc, b});
    else m_ovf = 1'b1;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() != 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovf;
    s[3] = m_ferr;
    s[11:8] = 4'(mq.size());
    return s;
  endfunction

  task automatic check_data_read(input string name);
    logic [31:0] v, e;
    bus_read(4'h0, v);
    e = '0;
    if (mq.size() != 0) begin
      e = {22'b0, 1'b1, mq[0]};
      void'(mq.pop_front());
    end
    chk(name, v, e);
  endtask

  task automatic send_random_frame(input int nbytes, input int partial);
    logic [7:0] b;
    logic       dc;
    cs_low();
    for (int k = 0; k < nbytes; k++) begin
      b  = 8'($urandom_range(0, 255));
      dc = 1'($urandom_range(0, 1));
      spi_bits(b, 8, dc);
      model_push(dc, b);
    end
    if (partial > 0) begin
      spi_bits(8'($urandom_range(0, 255)), partial, 1'b0);
      m_ferr = 1'b1;
    end
    cs_high();
  endtask

  initial begin
    logic [31:0] v;
    int nb, np, nr;

    tbl[0]  = '{0, 4'h0, 32'h0,        32'h0};
    tbl[1]  = '{0, 4'h4, 32'h0,        32'h0};
    tbl[2]  = '{0, 4'h8, 32'h0,        32'h0};
    tbl[3]  = '{0, 4'hC, 32'h0,        32'h0};
    tbl[4]  = '{1, 4'h4, 32'h1,        32'h0};
    tbl[5]  = '{0, 4'h4, 32'h0,        32'h1};
    tbl[6]  = '{1, 4'hC, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{0, 4'hC, 32'h0,        32'h0};
    tbl[8]  = '{1, 4'h8, 32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{0, 4'h8, 32'h0,        32'h0};
    tbl[10] = '{1, 4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[11] = '{0, 4'h0, 32'h0,        32'h0};
    tbl[12] = '{1, 4'h4, 32'hFFFFFFFE, 32'h0};
    tbl[13] = '{0, 4'h4, 32'h0,        32'h0};
    tbl[14] = '{1, 4'h4, 32'h1,        32'h0};
    tbl[15] = '{0, 4'h4, 32'h0,        32'h1};

    repeat (3) @(negedge clk);
    chk("reset_irq", {31'b0, irq_out}, 32'h0);
    chk("reset_rdata", read_value_out, 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_irq", {31'b0, irq_out}, 32'h0);

    // Register map table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].off, tbl[i].wdata);
      end else begin
        bus_read(tbl[i].off, v);
        chk($sformatf("tbl[%0d]", i), v, tbl[i].exp);
      end
    end

    // Read data is zero and ready follows select during a write
    @(negedge clk);
    address_in = 32'h4; sel_in = 1'b1; write_mask_in = 4'h1; write_value_in = 32'h1;
    #1;
    chk("rdata_zero_on_write", read_value_out, 32'h0);
    chk("ready_on_sel", {31'b0, ready_out}, 32'h1);
    @(negedge clk);
    bus_idle();
    #1 chk("ready_off", {31'b0, ready_out}, 32'h0);

    // Single byte 0xA5 with dc=1
    cs_low(); spi_bits(8'hA5, 8, 1'b1); cs_high();
    chk("a5_irq", {31'b0, irq_out}, 32'h1);
    bus_read(4'h0, v); chk("a5_data", v, 32'h3A5);
    bus_read(4'h8, v); chk("a5_status", v, 32'h0);
    repeat (2) @(negedge clk);
    chk("a5_irq_off", {31'b0, irq_out}, 32'h0);

    // Five bytes into a 4-deep FIFO
    cs_low();
    for (int i = 1; i <= 5; i++) spi_bits(8'(i), 8, 1'b0);
    cs_high();
    bus_read(4'h8, v); chk("ovf_status", v, 32'h407);
    for (int i = 1; i <= 4; i++) begin
      bus_read(4'h0, v); chk($sformatf("ovf_data%0d", i), v, 32'h200 + 32'(i));
    end
    bus_read(4'h8, v); chk("ovf_status_drained", v, 32'h004);
    bus_write(4'h4, 32'h3);
    bus_read(4'h8, v); chk("ovf_cleared", v, 32'h0);

    // Partial byte then cs_n high
    cs_low(); spi_bits(8'hFF, 5, 1'b0); cs_high();
    bus_read(4'h8, v); chk("ferr_status", v, 32'h008);
    bus_read(4'h0, v); chk("ferr_data_empty", v, 32'h0);
    bus_write(4'h4, 32'h3);
    bus_read(4'h8, v); chk("ferr_cleared", v, 32'h0);

    // Held DATA read pops once
    cs_low(); spi_bits(8'h11, 8, 1'b0); spi_bits(8'h22, 8, 1'b0); cs_high();
    @(negedge clk);
    address_in = 32'h0; sel_in = 1'b1; read_in = 1'b1;
    #1 chk("hold_first", read_value_out, 32'h211);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_idle();
    bus_read(4'h8, v); chk("hold_count", v, 32'h101);
    bus_read(4'h0, v); chk("hold_second", v, 32'h222);

    // Pop coincides with the push of a byte arriving into a full FIFO
    cs_low();
    for (int i = 0; i < 4; i++) spi_bits(8'h31 + 8'(i), 8, 1'b0);
    spi_bits(8'h35, 7, 1'b0);
    spi_mosi = 1'b1; lcd_dc = 1'b0;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk);
    address_in = 32'h0; sel_in = 1'b1; read_in = 1'b1;
    #1 chk("coinc_pop_data", read_value_out, 32'h231);
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    repeat (3) @(negedge clk);
    spi_clk = 1'b0;
    cs_high();
    bus_read(4'h8, v); chk("coinc_status", v, 32'h403);
    for (int i = 2; i <= 5; i++) begin
      bus_read(4'h0, v); chk($sformatf("coinc_data%0d", i), v, 32'h230 + 32'(i));
    end

    // Randomized frames against the model
    bus_write(4'h4, 32'h7);
    mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    for (int it = 0; it < 12; it++) begin
      nb = $urandom_range(0, 5);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      if (nb == 0 && np == 0) nb = 1;
      send_random_frame(nb, np);
      chk($sformatf("rnd%0d_irq", it), {31'b0, irq_out},
          {31'b0, (mq.size() != 0) || m_ovf || m_ferr});
      nr = $urandom_range(0, 4);
      for (int r = 0; r < nr; r++) check_data_read($sformatf("rnd%0d_data%0d", it, r));
      bus_read(4'h8, v); chk($sformatf("rnd%0d_status", it), v, model_status());
      if ($urandom_range(0, 2) == 0) begin
        bus_write(4'h4, 32'h3);
        m_ovf = 1'b0; m_ferr = 1'b0;
        bus_read(4'h8, v); chk($sformatf("rnd%0d_clr", it), v, model_status());
      end
    end

    // Disabling mid-byte discards it without a frame error
    bus_write(4'h4, 32'h7);
    cs_low(); spi_bits(8'hC3, 3, 1'b0);
    bus_write(4'h4, 32'h0);
    spi_bits(8'hFF, 5, 1'b0);
    cs_high();
    bus_read(4'h8, v); chk("disable_status", v, 32'h0);

    // Reset mid-byte, release with cs_n still low
    bus_write(4'h4, 32'h1);
    cs_low(); spi_bits(8'h96, 3, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    address_in = 32'h8; sel_in = 1'b1; read_in = 1'b1;
    #1;
    chk("rst_status", read_value_out, 32'h0);
    chk("rst_irq", {31'b0, irq_out}, 32'h0);
    address_in = 32'h4;
    #1 chk("rst_ctrl", read_value_out, 32'h0);
    bus_idle();
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    bus_write(4'h4, 32'h1);
    spi_bits(8'h96, 5, 1'b1);
    spi_bits(8'h77, 8, 1'b0);
    cs_high();
    bus_read(4'h8, v); chk("rst_tail_ignored", v, 32'h0);
    cs_low(); spi_bits(8'h5A, 8, 1'b0); cs_high();
    bus_read(4'h0, v); chk("rst_next_frame", v, 32'h25A);
    bus_read(4'h8, v); chk("rst_final_status", v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_target_rx.md
SPI_TARGET_RX -- requirements
Module: spi_target_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, RX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per SPI input (>=2).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address_in  input  32  bus address; offset = address_in[3:0].
REQ-006 sel_in  input  1  bus select.
REQ-007 read_in  input  1  bus read strobe.
REQ-008 write_mask_in  input  4  byte write enables; any bit set = write.
REQ-009 write_value_in  input  32  write data.
REQ-010 read_value_out  output  32  read data, combinational, 0 when not (sel_in && read_in).
REQ-011 ready_out  output  1  equals sel_in.
REQ-012 spi_clk  input  1  external SPI clock, async to clk, idle low.
REQ-013 spi_mosi  input  1  serial data, MSB first.
REQ-014 spi_cs_n  input  1  frame select, active low.
REQ-015 lcd_dc  input  1  data/command qualifier, captured per byte.
REQ-016 irq_out  output  1  level interrupt, registered.

Function
REQ-017 SHALL pass spi_clk, spi_mosi, spi_cs_n, and lcd_dc through SYNC_STAGES-flop synchronizers; correct operation SHALL require clk >= 4x spi_clk frequency.
REQ-018 SHALL detect spi_clk rising edges from the synchronized signal, one clk pulse per edge.
REQ-019 SHALL implement FSM IDLE -> SHIFT when synced cs_n is low and CTRL.enable=1; SHIFT -> IDLE when synced cs_n goes high or enable clears.
REQ-020 In SHIFT, each rising edge SHALL shift synced mosi into an 8-bit register LSB-side and increment a 3-bit bit counter.
REQ-021 On the 8th edge, SHALL push {synced lcd_dc, byte} to the FIFO on the following clk, reset the counter to 0, and remain in SHIFT for back-to-back bytes.
REQ-022 A push SHALL be visible as STATUS.not_empty no later than SYNC_STAGES+2 clk after the 8th spi_clk rising edge at the pin.
REQ-023 cs_n rising with bit counter != 0 SHALL discard the partial byte and set sticky STATUS.frame_error.
REQ-024 A push into a full FIFO SHALL drop the byte and set sticky STATUS.overflow; FIFO contents are unchanged.
REQ-025 A simultaneous push and pop SHALL both succeed, including when full (no overflow) and when empty-with-push (entry bypasses nothing; it becomes readable next cycle).
REQ-026 Offset 0x0 DATA read SHALL return {22'b0, valid, dc, byte[7:0]}; valid=0 and all else 0 when empty.
REQ-027 A DATA read SHALL pop exactly one entry on the first cycle of sel_in&&read_in (edge-detected); held reads SHALL not pop again; read when empty SHALL not pop.
REQ-028 Offset 0x4 CTRL: write bit0=enable, bit1=1 clears overflow and frame_error, bit2=1 flushes FIFO; bits 1-2 self-clear; read returns {31'b0, enable}.
REQ-029 Offset 0x8 STATUS read SHALL return bit0 not_empty, bit1 full, bit2 overflow, bit3 frame_error, bit4 frame_active (state==SHIFT), bits[11:8] entry count, others 0.
REQ-030 A clear written the same cycle a new overflow/frame_error event occurs SHALL leave the flag set.
REQ-031 Writes to offset 0x0, 0x8, 0xC SHALL be ignored; reads of 0xC SHALL return 0.
REQ-032 irq_out SHALL be registered enable && (not_empty || overflow || frame_error).
REQ-033 Clearing enable mid-byte SHALL discard the partial byte without setting frame_error.

Reset
REQ-034 reset_n low SHALL asynchronously force state IDLE, FIFO empty, counter 0, enable 0, flags 0, irq_out 0.
REQ-035 Synchronizer flops SHALL reset to idle levels: spi_clk 0, spi_cs_n 1, mosi 0, lcd_dc 0.
REQ-036 Reset asserted mid-frame SHALL discard all partial and buffered data; after release, reception SHALL begin only at the next cs_n falling edge with enable set.

Structure
REQ-037 Register offsets (0x0/0x4/0x8/0xC), STATUS/CTRL bit positions, and the FSM state enum SHALL live in shared package spi_pkg, also used by spi_controller.
REQ-038 The FIFO SHALL be sub-module spi_rx_fifo (parameterised depth, 9-bit entries, push/pop/flush, full/empty/count).

Verification
REQ-039 enable=1, send 0xA5 with lcd_dc=1 at clk/8 -> DATA reads 0x3A5, then STATUS.not_empty=0.
REQ-040 Send 5 bytes 0x01..0x05 in one frame, FIFO_DEPTH=4, no reads -> STATUS.overflow=1, count=4, reads return 0x201..0x204 (valid set, dc 0).
REQ-041 Raise cs_n after 5 bits -> frame_error=1, FIFO empty; CTRL write 0x3 -> flags 0.
REQ-042 Hold DATA read 3 cycles with 2 entries -> count drops 2->1 only.
REQ-043 FIFO full, 8th edge of new byte coincides with DATA read pop -> no overflow, count stays 4, new byte last.
REQ-044 Assert reset_n mid-byte -> all outputs 0; next full frame after release received correctly.
